// File: rtl/dac_update_arbiter_pkg.sv
// Shared types and defaults for the DAC update arbiter slice.
package dac_update_arbiter_pkg;

    localparam int unsigned DAC_WIDTH          = 16;
    localparam int unsigned DEF_GAP_CYCLES     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_update_arbiter_if.sv
// Requester / serializer bundle of the DAC update arbiter.
// The master side drives requests and the serializer load pulse;
// the slave side is the arbiter itself.
interface dac_update_arbiter_if #(
    parameter int unsigned NREQ = 4
) ();
    import dac_update_arbiter_pkg::*;

    localparam int unsigned IDW = id_width(NREQ);

    logic [NREQ-1:0]           req;
    logic [DAC_WIDTH*NREQ-1:0] req_data;
    logic [NREQ-1:0]           ack;
    logic                      dac_dv;
    logic [DAC_WIDTH-1:0]      dac_data;
    logic                      dac_ldac_n;
    logic [IDW-1:0]            grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        output req, req_data, dac_ldac_n,
        input  ack, dac_dv, dac_data, grant_id, busy, timeout_err
    );

    modport slave (
        input  req, req_data, dac_ldac_n,
        output ack, dac_dv, dac_data, grant_id, busy, timeout_err
    );

endinterface

// File: rtl/dac_update_arbiter_sync_fe_det.sv
// Two-flop synchronizer for an asynchronous active-low strobe, followed
// by a falling-edge detector producing a single-cycle pulse in clk domain.
module sync_fe_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic fe_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    // Flops idle high so a line held high through reset gives no edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            sync_dly_q <= 1'b1;
        end else begin
            meta_q     <= d_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign fe_o = sync_dly_q & ~sync_q;

endmodule

// File: rtl/dac_update_arbiter.sv
// Round-robin arbiter sharing one AD5541 serializer among NREQ requesters.
// A grant latches the winner's code, strobes the serializer once, waits for
// the load pulse (or a timeout), acknowledges the requester and then holds
// off for a fixed gap before the next grant.
module dac_update_arbiter
    import dac_update_arbiter_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic                 clk,
    input logic                 reset,
    dac_update_arbiter_if.slave bus
);

    localparam int unsigned IDW     = id_width(NREQ);
    localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    state_e               state_q, state_d;
    logic [DAC_WIDTH-1:0] data_q,  data_d;
    logic [IDW-1:0]       gid_q,   gid_d;
    logic                 terr_q,  terr_d;
    logic [CW-1:0]        cnt_q,   cnt_d;

    logic [NREQ-1:0]      ack_c;
    logic                 dv_c;
    logic                 done;
    logic [IDW-1:0]       winner;
    logic                 win_vld;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    sync_fe_det u_ldac_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.dac_ldac_n),
        .fe_o  (done)
    );

    // Round-robin pick: scan from last grant + 1; nearest candidate wins,
    // so the just-served requester ranks last.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int unsigned idx;
            idx = (32'(gid_q) + 32'(k)) % NREQ;
            if (bus.req[IDW'(idx)]) begin
                winner  = IDW'(idx);
                win_vld = 1'b1;
            end
        end
    end

    // Next-state and strobe decode; one counter serves both timeout and gap.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        gid_d   = gid_q;
        terr_d  = terr_q;
        cnt_d   = cnt_q;
        ack_c   = '0;
        dv_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    data_d  = bus.req_data[DAC_WIDTH*winner +: DAC_WIDTH];
                    gid_d   = winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                dv_c    = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    ack_c[gid_q] = 1'b1;
                    cnt_d        = '0;
                    state_d      = GAP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    ack_c[gid_q] = 1'b1;
                    terr_d       = 1'b1;
                    cnt_d        = '0;
                    state_d      = GAP;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            GAP: begin
                // A zero gap still spends this single cycle here.
                if ((32'(cnt_q) + 32'd1) >= GAP_CYCLES) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; grant index resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            gid_q   <= IDW'(NREQ - 1);
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ack         = ack_c;
    assign bus.dac_dv      = dv_c;
    assign bus.dac_data    = data_q;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Bench for dac_update_arbiter: directed scenarios followed by a randomized
// run, all checked against a transaction-level reference model.
module tb_dac_update_arbiter;
    import dac_update_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int GAP  = int'(DEF_GAP_CYCLES);
    localparam int TO   = int'(DEF_TIMEOUT_CYCLES);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dac_update_arbiter_if #(.NREQ(NREQ)) bus ();

    dac_update_arbiter #(
        .NREQ           (NREQ),
        .GAP_CYCLES     (DEF_GAP_CYCLES),
        .TIMEOUT_CYCLES (DEF_TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: pending requests, their codes, last grant,
    // cycle of last ack, cycle since which requests are pending, sticky error.
    logic [NREQ-1:0] m_req;
    logic [15:0]     m_data [NREQ];
    int              m_last;
    int              m_last_ack;
    int              m_pend;
    logic            m_terr;
    int              win;
    int              dv_cyc;
    int              prev_dv;
    int              k_rand;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_req();
        bus.req = m_req;
        for (int i = 0; i < NREQ; i++) bus.req_data[16*i +: 16] = m_data[i];
    endtask

    task automatic raise_bit(input int i, input logic [15:0] d);
        if (m_req == '0) m_pend = cyc;
        m_req[i]  = 1'b1;
        m_data[i] = d;
        apply_req();
    endtask

    // Next winner by the round-robin rule: first pending after the last grant.
    function automatic int rr_pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (m_req[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic do_reset(input bit keep_req);
        reset = 1'b0;
        if (!keep_req) m_req = '0;
        apply_req();
        bus.dac_ldac_n = 1'b1;
        tick();
        chk("rst_ack_early", 32'(bus.ack), 32'h0);
        tick();
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_dv", 32'(bus.dac_dv), 32'h0);
        chk("rst_data", 32'(bus.dac_data), 32'h0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'(NREQ - 1));
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_terr", 32'(bus.timeout_err), 32'h0);
        reset      = 1'b1;
        m_last     = NREQ - 1;
        m_last_ack = -1000;
        m_pend     = cyc;
        m_terr     = 1'b0;
    endtask

    // A grant happens one cycle after requests appear, but never before the
    // gap that follows the previous ack has elapsed.
    task automatic wait_dv();
        int   t = 0;
        int   exp_cyc;
        logic prev_busy;
        exp_cyc   = (m_pend + 1 > m_last_ack + GAP + 2) ? m_pend + 1 : m_last_ack + GAP + 2;
        win       = rr_pick();
        prev_busy = bus.busy;
        while (bus.dac_dv !== 1'b1 && t < 2*GAP + TO + 20) begin
            prev_busy = bus.busy;
            tick();
            t++;
        end
        chk("dv_seen", 32'(bus.dac_dv), 32'h1);
        chk("dv_cycle", 32'(cyc), 32'(exp_cyc));
        chk("busy_before_dv", 32'(prev_busy), 32'h0);
        chk("busy_at_dv", 32'(bus.busy), 32'h1);
        chk("grant_id", 32'(bus.grant_id), 32'(win));
        chk("dac_data", 32'(bus.dac_data), 32'(m_data[win]));
        dv_cyc = cyc;
        m_last = win;
    endtask

    // Pulse ldac_n low k cycles after dv (k<0: never). The ack follows the
    // falling edge by two cycles (two synchronizer flops, then the edge seen),
    // or comes exactly TIMEOUT cycles after dv. Request updates land on the
    // ack cycle itself.
    task automatic wait_ack(input int k, input bit drop, input logic [NREQ-1:0] raise);
        int t = 0;
        int exp_t;
        exp_t = (k < 0) ? TO : k + 2;
        while (t < TO + 10) begin
            if (bus.ack !== '0) break;
            if (t == k) bus.dac_ldac_n = 1'b0;
            tick();
            t++;
            if (t == 1) chk("dv_one_cycle", 32'(bus.dac_dv), 32'h0);
        end
        chk("ack_value", 32'(bus.ack), 32'h1 << win);
        chk("ack_latency", 32'(t), 32'(exp_t));
        chk("data_held", 32'(bus.dac_data), 32'(m_data[win]));
        if (k < 0) m_terr = 1'b1;
        bus.dac_ldac_n = 1'b1;
        m_last_ack     = cyc;
        if (drop) m_req[win] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (raise[i] && !m_req[i] && !(drop && i == win)) raise_bit(i, 16'($urandom));
        end
        if (raise != '0 && m_req == '0) raise_bit((win + 1) % NREQ, 16'($urandom));
        apply_req();
        tick();
        chk("ack_one_cycle", 32'(bus.ack), 32'h0);
        chk("busy_in_gap", 32'(bus.busy), 32'h1);
        chk("terr", 32'(bus.timeout_err), 32'(m_terr));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.dac_ldac_n = 1'b1;
        m_req          = '0;
        for (int i = 0; i < NREQ; i++) m_data[i] = 16'h0;
        m_terr         = 1'b0;
        m_last         = NREQ - 1;
        m_last_ack     = -1000;
        m_pend         = 0;
        prev_dv        = -1000;

        // Reset values, then a single requester served once
        do_reset(1'b0);
        raise_bit(0, 16'h1234);
        wait_dv();
        wait_ack(40, 1'b1, '0);

        // All four held continuously: strict rotation and minimum spacing
        do_reset(1'b0);
        for (int i = 0; i < NREQ; i++) raise_bit(i, 16'(i * 32'h1000));
        for (int n = 0; n < 5; n++) begin
            wait_dv();
            chk("rr_order", 32'(win), 32'(n % NREQ));
            if (n > 0) chk("dv_spacing", 32'(dv_cyc - prev_dv >= GAP + 3), 32'h1);
            prev_dv = dv_cyc;
            wait_ack(10 + n, 1'b0, '0);
        end

        // Timeout, then the error flag stays set through good transfers
        do_reset(1'b0);
        raise_bit(2, 16'hBEEF);
        wait_dv();
        wait_ack(-1, 1'b1, '0);
        raise_bit(0, 16'h0F0F);
        wait_dv();
        wait_ack(12, 1'b1, '0);
        raise_bit(3, 16'hA5A5);
        wait_dv();
        wait_ack(25, 1'b1, '0);

        // Spurious load pulse while idle must not produce an ack
        for (int i = 0; i < GAP + 3; i++) tick();
        bus.dac_ldac_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_pulse_ack", 32'(bus.ack), 32'h0);
            chk("idle_pulse_busy", 32'(bus.busy), 32'h0);
        end
        bus.dac_ldac_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_pulse_ack", 32'(bus.ack), 32'h0);
        end
        raise_bit(1, 16'h5A5A);
        wait_dv();
        wait_ack(7, 1'b1, '0);

        // Load pulse during the gap is ignored as well
        raise_bit(3, 16'h1357);
        wait_dv();
        wait_ack(9, 1'b1, '0);
        raise_bit(0, 16'h2468);
        bus.dac_ldac_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_pulse_ack", 32'(bus.ack), 32'h0);
        end
        bus.dac_ldac_n = 1'b1;
        wait_dv();
        wait_ack(11, 1'b1, '0);

        // Reset while waiting for the load: no ack, requester 0 served again
        do_reset(1'b0);
        raise_bit(0, 16'hC0DE);
        wait_dv();
        for (int i = 0; i < 10; i++) tick();
        chk("wait_no_ack", 32'(bus.ack), 32'h0);
        do_reset(1'b1);
        wait_dv();
        chk("reserve_req0", 32'(win), 32'h0);
        wait_ack(15, 1'b1, '0);

        // Requests change on the ack cycle: no double grant, none lost
        do_reset(1'b0);
        raise_bit(0, 16'h0001);
        raise_bit(1, 16'h0002);
        wait_dv();
        chk("chg_first", 32'(win), 32'h0);
        wait_ack(6, 1'b1, 4'b0100);
        wait_dv();
        chk("chg_second", 32'(win), 32'h1);
        wait_ack(8, 1'b1, '0);
        wait_dv();
        chk("chg_third", 32'(win), 32'h2);
        wait_ack(5, 1'b1, '0);

        // Randomized traffic
        raise_bit(int'($urandom_range(0, NREQ - 1)), 16'($urandom));
        for (int n = 0; n < 25; n++) begin
            wait_dv();
            k_rand = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 60));
            wait_ack(k_rand, $urandom_range(0, 3) != 0, NREQ'($urandom_range(1, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
